i2s_tx: RTL and testbench
=========================

I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 SHALL have parameter data_width, default 16, meaning sample and slot width in bits.
REQ-002 SHALL have parameter bclk_div, default 8 (legal >= 1), meaning clk cycles per bclk half-period.
REQ-003 SHALL have port clk  input  1  system clock; all logic on posedge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset; clock clk.
REQ-005 SHALL have port sample_in  input  data_width  signed mixed output sample.
REQ-006 SHALL have port sample_valid  input  1  one-cycle strobe qualifying sample_in.
REQ-007 SHALL have port sample_request  output  1  one-cycle pulse at each frame start.
REQ-008 SHALL have port underrun  output  1  one-cycle pulse: frame started with no new sample.
REQ-009 SHALL have port overrun  output  1  one-cycle pulse: unconsumed held sample overwritten.
REQ-010 SHALL have port bclk  output  1  I2S bit clock.
REQ-011 SHALL have port lrclk  output  1  I2S word select; 0 = left slot, 1 = right slot.
REQ-012 SHALL have port sdata  output  1  I2S serial data, MSB first.

Function
REQ-013 SHALL run div_cnt 0..bclk_div-1; at div_cnt == bclk_div-1, bclk toggles and div_cnt returns to 0.
REQ-014 SHALL treat the cycle in which bclk is driven 1->0 as a falling event (FE); sdata, lrclk, bit_cnt and shift change only on FE.
REQ-015 SHALL keep bit_cnt mod 2*data_width, incremented on each FE; lrclk <= 1 when new bit_cnt >= data_width, else 0.
REQ-016 SHALL keep a 2*data_width shift register; on every FE sdata <= shift MSB.
REQ-017 SHALL, on a non-wrap FE, shift left by 1 with 0 fill.
REQ-018 SHALL, on a wrap FE (new bit_cnt == 0), load shift with {word, word}: mono duplicated to both slots.
REQ-019 SHALL give I2S one-bit delay: left MSB on sdata one bclk after lrclk falls; right LSB is driven on the wrap FE.
REQ-020 SHALL hold incoming samples in a single register hold with flag full; sample_valid loads hold and sets full.
REQ-021 SHALL, on a wrap FE with full == 1, use hold as the frame word, copy it to last, and clear full.
REQ-022 SHALL, on a wrap FE with full == 0, use last as the frame word and pulse underrun.
REQ-023 SHALL pulse sample_request in the wrap FE cycle.
REQ-024 SHALL, on sample_valid while full == 1 and not the wrap FE cycle, overwrite hold and pulse overrun.
REQ-025 SHALL, on sample_valid in the wrap FE cycle, send the old hold/last contents in the frame.
REQ-026 SHALL, in that same case, load the new sample into hold, leave full == 1, and raise no overrun or underrun.
REQ-027 SHALL treat sample data as raw bits, with no arithmetic, truncation or saturation.
REQ-028 SHALL give a frame period of exactly 4*data_width*bclk_div clk cycles.

Reset
REQ-029 SHALL, on reset, set bclk=0, lrclk=1, sdata=0, div_cnt=0, bit_cnt=2*data_width-1.
REQ-030 SHALL, on reset, set shift=0, hold=0, last=0, full=0, sample_request=0, underrun=0, overrun=0.
REQ-031 SHALL give reset priority over all other activity; reset mid-frame abandons the frame, with no partial word resumed.
REQ-032 SHALL make the first FE after reset release, at clk cycle 2*bclk_div, a wrap FE.

Verification
REQ-033 SHALL cover: data_width=16, bclk_div=2, reset, then sample 0xA5C3 before the first FE.
- Required: sample_request at cycle 4; no underrun.
- Required: next 32 bits are A5C3 (lrclk 0), then A5C3 (lrclk 1), MSB first with one-bit delay.
REQ-034 SHALL cover: no sample after reset -> underrun pulses at each wrap FE; sdata stays 0.
REQ-035 SHALL cover: samples 0x1111 then 0x2222 within one frame -> one overrun pulse; next frame carries 0x2222.
REQ-036 SHALL cover: sample_valid (0x7FFF) coincident with a wrap FE while hold=0x8000 is full.
- Required: current frame 0x8000, next frame 0x7FFF, no overrun.
REQ-037 SHALL cover: one sample then none -> next frames repeat it with underrun pulses; bclk period 4 clk; lrclk period 128 clk.
REQ-038 SHALL cover: reset asserted at bit 20 of a frame -> outputs at reset values next cycle; next wrap FE at cycle 4 after release.

Source files
------------

// File: rtl/i2s_tx.sv
// I2S transmitter: mono samples are duplicated into both stereo slots and shifted out MSB first.
// A single hold register with a full flag decouples sample arrival from the frame timing.
module i2s_tx #(
   parameter int data_width = 16,
   parameter int bclk_div   = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [data_width-1:0] sample_in,
   input  logic                  sample_valid,
   output logic                  sample_request,
   output logic                  underrun,
   output logic                  overrun,
   output logic                  bclk,
   output logic                  lrclk,
   output logic                  sdata
);

   localparam int DIV_W = (bclk_div > 1) ? $clog2(bclk_div) : 1;
   localparam int BIT_W = $clog2(2 * data_width);
   localparam int SH_W  = 2 * data_width;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(bclk_div - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * data_width - 1);
   localparam logic [BIT_W-1:0] BIT_HALF = BIT_W'(data_width);

   logic [DIV_W-1:0]      r_div_cnt;
   logic [BIT_W-1:0]      r_bit_cnt;
   logic [SH_W-1:0]       r_shift;
   logic [data_width-1:0] r_hold;
   logic [data_width-1:0] r_last;
   logic                  r_full;
   logic                  r_bclk;
   logic                  r_lrclk;
   logic                  r_sdata;
   logic                  r_sample_request;
   logic                  r_underrun;
   logic                  r_overrun;

   logic                  w_div_end;
   logic                  w_fe;
   logic                  w_wrap;
   logic [BIT_W-1:0]      w_bit_nxt;
   logic [data_width-1:0] w_word;

   // Falling-edge and frame-wrap detection; the frame word is sampled before any same-cycle load.
   always_comb begin
      w_div_end = (r_div_cnt == DIV_LAST);
      w_fe      = w_div_end & r_bclk;
      if (r_bit_cnt == BIT_LAST) begin
         w_bit_nxt = BIT_W'(0);
      end else begin
         w_bit_nxt = r_bit_cnt + BIT_W'(1);
      end
      w_wrap = w_fe & (w_bit_nxt == BIT_W'(0));
      if (r_full) begin
         w_word = r_hold;
      end else begin
         w_word = r_last;
      end
   end

   // Bit clock generation, serializer and sample holding register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_div_cnt        <= DIV_W'(0);
         r_bit_cnt        <= BIT_LAST;
         r_shift          <= SH_W'(0);
         r_hold           <= data_width'(0);
         r_last           <= data_width'(0);
         r_full           <= 1'b0;
         r_bclk           <= 1'b0;
         r_lrclk          <= 1'b1;
         r_sdata          <= 1'b0;
         r_sample_request <= 1'b0;
         r_underrun       <= 1'b0;
         r_overrun        <= 1'b0;
      end else begin
         r_sample_request <= 1'b0;
         r_underrun       <= 1'b0;
         r_overrun        <= 1'b0;

         if (w_div_end) begin
            r_div_cnt <= DIV_W'(0);
            r_bclk    <= ~r_bclk;
         end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
         end

         // sdata takes the old MSB, giving the one-bit delay relative to lrclk.
         if (w_fe) begin
            r_bit_cnt <= w_bit_nxt;
            r_lrclk   <= (w_bit_nxt >= BIT_HALF);
            r_sdata   <= r_shift[SH_W-1];
            if (w_wrap) begin
               r_shift <= {w_word, w_word};
            end else begin
               r_shift <= {r_shift[SH_W-2:0], 1'b0};
            end
         end

         if (w_wrap) begin
            r_sample_request <= 1'b1;
            if (r_full) begin
               r_last <= r_hold;
            end
            // A sample arriving exactly at the wrap refills hold for the next frame.
            if (sample_valid) begin
               r_hold <= sample_in;
               r_full <= 1'b1;
            end else begin
               r_full     <= 1'b0;
               r_underrun <= ~r_full;
            end
         end else if (sample_valid) begin
            r_hold    <= sample_in;
            r_full    <= 1'b1;
            r_overrun <= r_full;
         end
      end
   end

   assign sample_request = r_sample_request;
   assign underrun       = r_underrun;
   assign overrun        = r_overrun;
   assign bclk           = r_bclk;
   assign lrclk          = r_lrclk;
   assign sdata          = r_sdata;

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx with data_width=16, bclk_div=2 (falling bclk edge every 4 clk, frame 128 clk).
module tb_i2s_tx;

   logic        clk;
   logic        reset;
   logic [15:0] sample_in;
   logic        sample_valid;
   logic        sample_request;
   logic        underrun;
   logic        overrun;
   logic        bclk;
   logic        lrclk;
   logic        sdata;

   int n_checks;
   int n_fail;

   i2s_tx #(.data_width(16), .bclk_div(2)) dut (
      .clk           (clk),
      .reset         (reset),
      .sample_in     (sample_in),
      .sample_valid  (sample_valid),
      .sample_request(sample_request),
      .underrun      (underrun),
      .overrun       (overrun),
      .bclk          (bclk),
      .lrclk         (lrclk),
      .sdata         (sdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_bclk"}, {31'd0, bclk}, 32'd0);
      chk({tag, "_lrclk"}, {31'd0, lrclk}, 32'd1);
      chk({tag, "_sdata"}, {31'd0, sdata}, 32'd0);
      chk({tag, "_pulses"}, {29'd0, sample_request, underrun, overrun}, 32'd0);
   endtask

   // Runs one 128-cycle frame starting right after a wrap edge; optional samples at ticks a and b.
   task automatic run_frame(input int a, input logic [15:0] va, input int b, input logic [15:0] vb,
                            output logic [31:0] frame, output int n_req, output int n_und,
                            output int n_ov);
      frame = 32'd0;
      n_req = 0;
      n_und = 0;
      n_ov  = 0;
      for (int t = 1; t <= 128; t++) begin
         if (t == a) begin
            sample_valid = 1'b1;
            sample_in    = va;
         end else if (t == b) begin
            sample_valid = 1'b1;
            sample_in    = vb;
         end else begin
            sample_valid = 1'b0;
         end
         tick();
         n_req += int'(sample_request);
         n_und += int'(underrun);
         n_ov  += int'(overrun);
         if (t % 4 == 0) frame = {frame[30:0], sdata};
         if (t == 1)   chk("bclk_lo_t1", {31'd0, bclk}, 32'd0);
         if (t == 2)   chk("bclk_hi_t2", {31'd0, bclk}, 32'd1);
         if (t == 4)   chk("lrclk_left_start", {31'd0, lrclk}, 32'd0);
         if (t == 60)  chk("lrclk_left_end", {31'd0, lrclk}, 32'd0);
         if (t == 64)  chk("lrclk_right_start", {31'd0, lrclk}, 32'd1);
         if (t == 124) chk("lrclk_right_end", {31'd0, lrclk}, 32'd1);
         if (t == 128) chk("lrclk_wrap", {31'd0, lrclk}, 32'd0);
      end
      sample_valid = 1'b0;
   endtask

   task automatic chk_frame(input string tag, input logic [31:0] frame, input logic [15:0] word,
                            input int n_req, input int n_und, input int n_ov,
                            input int e_und, input int e_ov);
      chk({tag, "_left"}, {16'd0, frame[31:16]}, {16'd0, word});
      chk({tag, "_right"}, {16'd0, frame[15:0]}, {16'd0, word});
      chk({tag, "_req"}, n_req, 32'd1);
      chk({tag, "_underrun"}, n_und, e_und);
      chk({tag, "_overrun"}, n_ov, e_ov);
   endtask

   initial begin
      logic [31:0] f;
      int          nr;
      int          nu;
      int          no;

      n_checks     = 0;
      n_fail       = 0;
      reset        = 1'b1;
      sample_valid = 1'b0;
      sample_in    = 16'h0000;
      repeat (3) tick();
      chk_reset_outputs("reset");

      // Release reset with 0xA5C3 presented in the very first cycle.
      reset        = 1'b0;
      sample_valid = 1'b1;
      sample_in    = 16'hA5C3;
      tick();
      sample_valid = 1'b0;
      tick();
      tick();
      chk("first_req_early", {31'd0, sample_request}, 32'd0);
      tick();
      chk("first_req_cycle4", {31'd0, sample_request}, 32'd1);
      chk("first_no_underrun", {31'd0, underrun}, 32'd0);
      chk("first_no_overrun", {31'd0, overrun}, 32'd0);

      run_frame(0, 16'h0000, 0, 16'h0000, f, nr, nu, no);
      chk_frame("frame_a5c3", f, 16'hA5C3, nr, nu, no, 1, 0);

      run_frame(0, 16'h0000, 0, 16'h0000, f, nr, nu, no);
      chk_frame("frame_repeat", f, 16'hA5C3, nr, nu, no, 1, 0);

      run_frame(10, 16'h1111, 50, 16'h2222, f, nr, nu, no);
      chk_frame("frame_overrun", f, 16'hA5C3, nr, nu, no, 0, 1);

      run_frame(20, 16'h8000, 128, 16'h7FFF, f, nr, nu, no);
      chk_frame("frame_2222", f, 16'h2222, nr, nu, no, 0, 0);

      run_frame(0, 16'h0000, 0, 16'h0000, f, nr, nu, no);
      chk_frame("frame_8000", f, 16'h8000, nr, nu, no, 0, 0);

      run_frame(0, 16'h0000, 0, 16'h0000, f, nr, nu, no);
      chk_frame("frame_7fff", f, 16'h7FFF, nr, nu, no, 1, 0);

      // Reset in the middle of a frame, right after bit 20 is shifted out.
      repeat (80) tick();
      reset = 1'b1;
      tick();
      chk_reset_outputs("midreset");
      reset = 1'b0;
      tick();
      tick();
      tick();
      chk("mid_req_early", {31'd0, sample_request}, 32'd0);
      tick();
      chk("mid_req_cycle4", {31'd0, sample_request}, 32'd1);
      chk("mid_underrun", {31'd0, underrun}, 32'd1);

      run_frame(0, 16'h0000, 0, 16'h0000, f, nr, nu, no);
      chk_frame("frame_empty", f, 16'h0000, nr, nu, no, 1, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
